// File: rtl/pipeline_pkg.sv
// Shared pipeline control types: FSM state encoding, register index width,
// and the stage-control bundle used by the hazard controller.
package pipeline_pkg;

  localparam int REG_IDX_W = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    HALTED   = 2'd3
  } hcu_state_e;

  // Bit order: pc_en ifid_en idex_en exmem_en memwb_en ifid_flush idex_flush memwb_flush
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      ctrl;
    hcu_state_e next;
  } decision_t;

  localparam ctrl_t CTRL_RUN    = 8'b11111_000;
  localparam ctrl_t CTRL_FREEZE = 8'b00000_001;
  localparam ctrl_t CTRL_BRANCH = 8'b11111_110;
  localparam ctrl_t CTRL_LU     = 8'b00111_010;
  localparam ctrl_t CTRL_HALT   = 8'b01111_100;
  localparam ctrl_t CTRL_RESET  = 8'b00000_111;

  // Priority-ordered hazard resolution shared by RUN, LU_STALL and MEM_WAIT.
  function automatic decision_t run_rules(input logic mwait, input logic branch,
                                          input logic lu, input logic halt);
    decision_t d;
    d.ctrl = CTRL_RUN;
    d.next = RUN;
    if (mwait) begin
      d.ctrl = CTRL_FREEZE;
      d.next = MEM_WAIT;
    end else if (branch) begin
      // ID is flushed, so any coincident load-use hazard is moot
      d.ctrl = CTRL_BRANCH;
      d.next = RUN;
    end else if (lu) begin
      d.ctrl = CTRL_LU;
      d.next = LU_STALL;
    end else if (halt) begin
      d.ctrl = CTRL_HALT;
      d.next = HALTED;
    end
    return d;
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Hazard-detection inputs from the pipeline and stage-control outputs back to it.
interface hazard_control_unit_if;
  import pipeline_pkg::*;

  logic                 id_valid;
  logic [REG_IDX_W-1:0] id_src;
  logic [REG_IDX_W-1:0] id_dst;
  logic                 id_uses_src;
  logic                 id_uses_dst;
  logic                 ex_valid;
  logic                 ex_mem_read;
  logic                 ex_wb;
  logic [REG_IDX_W-1:0] ex_dst;
  logic                 ex_branch_taken;
  logic                 mem_req;
  logic                 mem_ready;
  logic                 halt;
  logic                 resume;

  logic pc_en;
  logic ifid_en;
  logic idex_en;
  logic exmem_en;
  logic memwb_en;
  logic ifid_flush;
  logic idex_flush;
  logic memwb_flush;

  // Pipeline side: reports hazards, receives enables/flushes
  modport master (
    output id_valid, id_src, id_dst, id_uses_src, id_uses_dst,
           ex_valid, ex_mem_read, ex_wb, ex_dst, ex_branch_taken,
           mem_req, mem_ready, halt, resume,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_flush
  );

  // Controller side
  modport slave (
    input  id_valid, id_src, id_dst, id_uses_src, id_uses_dst,
           ex_valid, ex_mem_read, ex_wb, ex_dst, ex_branch_taken,
           mem_req, mem_ready, halt, resume,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, memwb_flush
  );
endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear, else increment unless already all-ones
  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (inc && (count_q != {WIDTH{1'b1}}))
      count_d = count_q + 1'b1;
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard sequencer: load-use, memory wait, taken branch and halt.
// Stage controls are Mealy (same-cycle response); held at bubble values in reset.
//
// state    | meaning
// RUN      | normal flow, hazards resolved combinationally
// LU_STALL | one bubble inserted for a load-use; lu ignored this cycle
// MEM_WAIT | pipeline frozen until mem_ready
// HALTED   | fetch stopped, downstream drains until resume
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_control_unit_if.slave bus,
  output logic [1:0]           state,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic                 mem_timeout
);

  localparam logic [15:0] TIMEOUT_M1 = 16'(MEM_TIMEOUT - 1);

  hcu_state_e  state_q, state_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic        lu, mwait;
  ctrl_t       ctrl;
  decision_t   dec;
  logic [15:0] wait_cnt;

  // Hazard detection and next-state / control selection
  always_comb begin
    lu = bus.ex_valid & bus.ex_mem_read & bus.ex_wb & bus.id_valid &
         ((bus.id_uses_src & (bus.id_src == bus.ex_dst)) |
          (bus.id_uses_dst & (bus.id_dst == bus.ex_dst)));
    mwait = bus.mem_req & ~bus.mem_ready;

    dec = run_rules(mwait, bus.ex_branch_taken,
                    lu & (state_q != LU_STALL), bus.halt);
    ctrl    = dec.ctrl;
    state_d = dec.next;

    if (state_q == HALTED) begin
      if (mwait) begin
        ctrl    = CTRL_FREEZE;
        state_d = HALTED;
      end else if (bus.resume) begin
        ctrl    = CTRL_RUN;
        state_d = RUN;
      end else begin
        ctrl    = CTRL_HALT;
        state_d = HALTED;
      end
    end

    if (!rst_n) ctrl = CTRL_RESET;

    mem_timeout_d = mem_timeout_q | (mwait & (wait_cnt >= TIMEOUT_M1));
  end

  // FSM state and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  sat_counter #(.WIDTH(16)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mwait),
    .clear (~mwait),
    .count (wait_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~ctrl.pc_en),
    .clear (1'b0),
    .count (stall_cycles)
  );

  assign bus.pc_en       = ctrl.pc_en;
  assign bus.ifid_en     = ctrl.ifid_en;
  assign bus.idex_en     = ctrl.idex_en;
  assign bus.exmem_en    = ctrl.exmem_en;
  assign bus.memwb_en    = ctrl.memwb_en;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.memwb_flush = ctrl.memwb_flush;

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (MEM_TIMEOUT=3, CNT_W=8).
module tb_hazard_control_unit;

  localparam int CNT_W = 8;

  // Expected control vectors: pc ifid idex exmem memwb | ifid_f idex_f memwb_f
  localparam logic [7:0] E_RUN    = 8'b11111_000;
  localparam logic [7:0] E_FREEZE = 8'b00000_001;
  localparam logic [7:0] E_BRANCH = 8'b11111_110;
  localparam logic [7:0] E_LU     = 8'b00111_010;
  localparam logic [7:0] E_HALT   = 8'b01111_100;
  localparam logic [7:0] E_RESET  = 8'b00000_111;

  logic             clk;
  logic             rst_n;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cycles;
  logic             mem_timeout;
  int               n_chk;
  int               n_fail;

  hazard_control_unit_if bus();

  hazard_control_unit #(.MEM_TIMEOUT(3), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .state        (state),
    .stall_cycles (stall_cycles),
    .mem_timeout  (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ctrl_obs();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.memwb_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_src = 0; bus.id_dst = 0;
    bus.id_uses_src = 0; bus.id_uses_dst = 0;
    bus.ex_valid = 0; bus.ex_mem_read = 0; bus.ex_wb = 0; bus.ex_dst = 0;
    bus.ex_branch_taken = 0; bus.mem_req = 0; bus.mem_ready = 0;
    bus.halt = 0; bus.resume = 0;
  endtask

  task automatic set_lu();
    bus.ex_valid = 1; bus.ex_mem_read = 1; bus.ex_wb = 1; bus.ex_dst = 3'd3;
    bus.id_valid = 1; bus.id_src = 3'd3; bus.id_uses_src = 1;
  endtask

  task automatic reset_dut();
    rst_n = 0;
    #1;
    @(negedge clk);
    rst_n = 1;
    cyc();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    idle_inputs();
    rst_n = 0;
    #2;
    chk("reset_ctrl", 32'(ctrl_obs()), 32'(E_RESET));
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_stall", 32'(stall_cycles), 32'd0);
    chk("reset_timeout", 32'(mem_timeout), 32'd0);
    @(negedge clk);
    rst_n = 1;
    cyc();
    chk("post_reset_ctrl", 32'(ctrl_obs()), 32'(E_RUN));
    chk("post_reset_stall", 32'(stall_cycles), 32'd0);

    // Load-use: one bubble
    set_lu();
    #1;
    chk("lu_ctrl", 32'(ctrl_obs()), 32'(E_LU));
    cyc();
    chk("lu_state", 32'(state), 32'd1);
    chk("lu_stall_ctrl", 32'(ctrl_obs()), 32'(E_RUN));
    cyc();
    chk("lu_back_run", 32'(state), 32'd0);
    chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);

    // Branch overrides coincident load-use
    bus.ex_branch_taken = 1;
    #1;
    chk("br_ctrl", 32'(ctrl_obs()), 32'(E_BRANCH));
    cyc();
    chk("br_state", 32'(state), 32'd0);
    chk("br_stall_cnt", 32'(stall_cycles), 32'd1);
    idle_inputs();

    // Memory stall of 4 cycles
    reset_dut();
    bus.mem_req = 1;
    bus.mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mw_ctrl_%0d", i), 32'(ctrl_obs()), 32'(E_FREEZE));
      cyc();
      chk($sformatf("mw_state_%0d", i), 32'(state), 32'd2);
    end
    bus.mem_ready = 1;
    #1;
    chk("mw_release_ctrl", 32'(ctrl_obs()), 32'(E_RUN));
    cyc();
    chk("mw_release_state", 32'(state), 32'd0);
    chk("mw_stall_cnt", 32'(stall_cycles), 32'd4);
    idle_inputs();

    // Timeout: sets on the 3rd wait edge, sticky; held branch acted on at release
    reset_dut();
    bus.mem_req = 1;
    bus.mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("to_flag_%0d", i), 32'(mem_timeout), (i >= 2) ? 32'd1 : 32'd0);
    end
    bus.mem_ready = 1;
    bus.ex_branch_taken = 1;
    #1;
    chk("to_release_branch", 32'(ctrl_obs()), 32'(E_BRANCH));
    cyc();
    chk("to_release_state", 32'(state), 32'd0);
    chk("to_sticky", 32'(mem_timeout), 32'd1);
    idle_inputs();
    cyc();
    chk("to_sticky_idle", 32'(mem_timeout), 32'd1);

    // Halt for 6 stalled cycles, then resume
    reset_dut();
    bus.halt = 1;
    #1;
    chk("halt_ctrl", 32'(ctrl_obs()), 32'(E_HALT));
    cyc();
    bus.halt = 0;
    chk("halt_state", 32'(state), 32'd3);
    chk("halted_ctrl", 32'(ctrl_obs()), 32'(E_HALT));
    repeat (5) cyc();
    bus.resume = 1;
    #1;
    chk("resume_ctrl", 32'(ctrl_obs()), 32'(E_RUN));
    cyc();
    bus.resume = 0;
    chk("resume_state", 32'(state), 32'd0);
    chk("halt_stall_cnt", 32'(stall_cycles), 32'd6);

    // Saturation: 2^CNT_W+5 stalled cycles
    reset_dut();
    bus.halt = 1;
    cyc();
    bus.halt = 0;
    repeat ((1 << CNT_W) + 4) cyc();
    chk("stall_saturate", 32'(stall_cycles), 32'hFF);
    bus.resume = 1;
    cyc();
    bus.resume = 0;
    chk("sat_resume_state", 32'(state), 32'd0);

    // Reset mid-MEM_WAIT
    reset_dut();
    bus.mem_req = 1;
    bus.mem_ready = 0;
    cyc();
    cyc();
    chk("rst_mw_state_pre", 32'(state), 32'd2);
    #2;
    rst_n = 0;
    #1;
    chk("rst_mw_ctrl", 32'(ctrl_obs()), 32'(E_RESET));
    chk("rst_mw_state", 32'(state), 32'd0);
    chk("rst_mw_stall", 32'(stall_cycles), 32'd0);
    bus.mem_req = 0;
    @(negedge clk);
    rst_n = 1;
    cyc();
    chk("rst_mw_after_state", 32'(state), 32'd0);
    chk("rst_mw_after_stall", 32'(stall_cycles), 32'd0);
    // Wait counter must restart from 0: flag only on the 3rd new wait edge
    bus.mem_req = 1;
    cyc();
    cyc();
    chk("rst_mw_wait_cleared", 32'(mem_timeout), 32'd0);
    cyc();
    chk("rst_mw_wait_third", 32'(mem_timeout), 32'd1);
    idle_inputs();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
